// File: rtl/snake_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snake_pkg : direction encoding, FSM states and grid defaults shared by the
//             snake motion controller and the renderer.
// Revision  : 1.0
// ---------------------------------------------------------------------------
package snake_pkg;

  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 24;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_LEFT  = 4'b0001;
  localparam dir_t DIR_RIGHT = 4'b0010;
  localparam dir_t DIR_UP    = 4'b0100;
  localparam dir_t DIR_DOWN  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  function automatic logic is_onehot(input dir_t d);
    is_onehot = (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
  endfunction

  function automatic dir_t opposite_dir(input dir_t d);
    dir_t opp;
    opp = 4'b0000;
    case (d)
      DIR_LEFT:  opp = DIR_RIGHT;
      DIR_RIGHT: opp = DIR_LEFT;
      DIR_UP:    opp = DIR_DOWN;
      DIR_DOWN:  opp = DIR_UP;
      default:   opp = 4'b0000;
    endcase
    opposite_dir = opp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_tick_gen : modulo-TICK_DIV counter with run/hold and clear controls,
//                 emitting a terminal-count pulse while running.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module game_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tc
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  assign o_tc = i_run && (r_count == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= o_tc ? '0 : r_count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/snake_motion_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// snake_motion_ctrl : filters one-hot direction requests and steps the snake
//                     head once per game tick with edge wrap-around.
// Option            : SNAKE_WALL_COLLIDE_EN - edges become lethal walls.
// Revision          : 1.0
// ---------------------------------------------------------------------------
module snake_motion_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [3:0]                direction_in,
  output logic [$clog2(GRID_W)-1:0] head_x,
  output logic [$clog2(GRID_H)-1:0] head_y,
  output logic [3:0]                cur_dir,
  output logic                      step,
  output logic                      crash
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

`ifdef SNAKE_WALL_COLLIDE_EN
  localparam bit WALL_EN = 1'b1;
`else
  localparam bit WALL_EN = 1'b0;
`endif

  state_t        r_state;
  logic [XW-1:0] r_head_x;
  logic [YW-1:0] r_head_y;
  dir_t          r_cur_dir;
  dir_t          r_pending_dir;
  logic          r_step;
  logic          r_crash;

  logic [XW-1:0] w_next_x;
  logic [YW-1:0] w_next_y;
  logic          w_wall;
  logic          w_tc;
  logic          w_run;
  logic          w_clear;
  logic          w_req_valid;
  logic          w_req_ok;

  assign w_run   = (r_state == S_RUN);
  assign w_clear = (r_state == S_IDLE);

  game_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_run   (w_run),
    .i_clear (w_clear),
    .o_tc    (w_tc)
  );

  // In IDLE any direction is accepted; afterwards reversals of cur_dir are dropped.
  assign w_req_valid = is_onehot(direction_in);
  assign w_req_ok    = w_req_valid &&
                       ((r_state == S_IDLE) || (direction_in != opposite_dir(r_cur_dir)));

  always_comb begin
    w_next_x = r_head_x;
    w_next_y = r_head_y;
    w_wall   = 1'b0;
    case (r_pending_dir)
      DIR_LEFT: begin
        if (r_head_x == '0) begin
          w_next_x = X_MAX;
          w_wall   = 1'b1;
        end else begin
          w_next_x = r_head_x - XW'(1);
        end
      end
      DIR_RIGHT: begin
        if (r_head_x == X_MAX) begin
          w_next_x = '0;
          w_wall   = 1'b1;
        end else begin
          w_next_x = r_head_x + XW'(1);
        end
      end
      DIR_UP: begin
        if (r_head_y == '0) begin
          w_next_y = Y_MAX;
          w_wall   = 1'b1;
        end else begin
          w_next_y = r_head_y - YW'(1);
        end
      end
      DIR_DOWN: begin
        if (r_head_y == Y_MAX) begin
          w_next_y = '0;
          w_wall   = 1'b1;
        end else begin
          w_next_y = r_head_y + YW'(1);
        end
      end
      default: begin
        w_next_x = r_head_x;
        w_next_y = r_head_y;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_head_x      <= XW'(START_X);
      r_head_y      <= YW'(START_Y);
      r_cur_dir     <= DIR_RIGHT;
      r_pending_dir <= DIR_RIGHT;
      r_step        <= 1'b0;
      r_crash       <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (w_req_ok && (r_state != S_DEAD)) begin
        r_pending_dir <= direction_in;
      end
      case (r_state)
        S_IDLE: begin
          if (enable && w_req_valid) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!enable) begin
            r_state <= S_PAUSE;
          end
          // A terminal count still steps even if enable drops in the same cycle.
          if (w_tc) begin
            if (WALL_EN && w_wall) begin
              r_crash <= 1'b1;
              r_state <= S_DEAD;
            end else begin
              r_step    <= 1'b1;
              r_cur_dir <= r_pending_dir;
              r_head_x  <= w_next_x;
              r_head_y  <= w_next_y;
            end
          end
        end
        S_PAUSE: begin
          if (enable) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_DEAD;
        end
      endcase
    end
  end

  assign head_x  = r_head_x;
  assign head_y  = r_head_y;
  assign cur_dir = r_cur_dir;
  assign step    = r_step;
  assign crash   = r_crash & WALL_EN;

endmodule
`default_nettype wire
